// File: rtl/mem_wb.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb
// Brief   : MEM/WB pipeline register with write-back mux, retire counter and
//           sticky halt flag.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic [14:0]      ctrl_msg,
    input  logic [31:0]      alu,
    input  logic [31:0]      mem_data,
    input  logic [31:0]      pc4,
    input  logic             valid_in,
    input  logic             go,
    input  logic             clear,
    output logic [31:0]      instruction_out,
    output logic [14:0]      ctrl_msg_out,
    output logic [31:0]      wb_data,
    output logic [4:0]       wb_reg,
    output logic             wb_en,
    output logic             valid_out,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    localparam logic [4:0]       c_LINK_REG = 5'd31;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_instruction;
    logic [14:0]      r_ctrl;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_wb_reg;
    logic             r_valid;
    logic [CNT_W-1:0] r_retired;
    logic             r_halted;

    logic [31:0]      w_wb_data;
    logic [4:0]       w_wb_reg;
    logic             w_commit;
    logic             w_halt;

    always_comb begin
        w_wb_data = alu;
        w_wb_reg  = instruction[20:16];
        // jal outranks mem_to_reg; the link register is fixed
        if (ctrl_msg[2]) begin
            w_wb_data = pc4;
        end else if (ctrl_msg[1]) begin
            w_wb_data = mem_data;
        end
        if (ctrl_msg[2]) begin
            w_wb_reg = c_LINK_REG;
        end else if (ctrl_msg[4]) begin
            w_wb_reg = instruction[15:11];
        end
        w_commit = valid_in & (ctrl_msg[0] | ctrl_msg[3]);
        w_halt   = valid_in & ctrl_msg[3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction <= '0;
            r_ctrl        <= '0;
            r_wb_data     <= '0;
            r_wb_reg      <= '0;
            r_valid       <= 1'b0;
            r_retired     <= '0;
            r_halted      <= 1'b0;
        end else if (r_halted) begin
            // frozen until reset
        end else if (clear) begin
            // counter and halt flag are architectural state, not stage data
            r_instruction <= '0;
            r_ctrl        <= '0;
            r_wb_data     <= '0;
            r_wb_reg      <= '0;
            r_valid       <= 1'b0;
        end else if (go) begin
            r_instruction <= instruction;
            r_ctrl        <= ctrl_msg;
            r_wb_data     <= w_wb_data;
            r_wb_reg      <= w_wb_reg;
            r_valid       <= valid_in;
            if (w_commit) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
            if (w_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign instruction_out = r_instruction;
    assign ctrl_msg_out    = r_ctrl;
    assign wb_data         = r_wb_data;
    assign wb_reg          = r_wb_reg;
    assign wb_en           = r_valid & r_ctrl[0];
    assign valid_out       = r_valid;
    assign retired         = r_retired;
    assign halted          = r_halted;

endmodule
`default_nettype wire

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 instruction  in  32  instruction word leaving the MEM stage.
REQ-005 ctrl_msg  in  15  control word; bit0 reg_write, bit1 mem_to_reg, bit2 jal, bit3 halt, bit4 reg_dst; bits 14:5 carried through, not interpreted.
REQ-006 alu  in  32  ALU result from EXE_MEM.
REQ-007 mem_data  in  32  data-memory read data, valid in the same cycle as the other inputs.
REQ-008 pc4  in  32  PC+4 of the instruction, the link value for jal.
REQ-009 valid_in  in  1  inputs carry a real instruction, not a bubble.
REQ-010 go  in  1  capture enable; 0 = stall (hold).
REQ-011 clear  in  1  flush; inserts a bubble.
REQ-012 instruction_out  out  32  registered instruction.
REQ-013 ctrl_msg_out  out  15  registered control word.
REQ-014 wb_data  out  32  registered write-back value.
REQ-015 wb_reg  out  5  registered destination register number.
REQ-016 wb_en  out  1  register-file write enable, equal to valid_out AND ctrl_msg_out bit0.
REQ-017 valid_out  out  1  registered valid.
REQ-018 retired  out  CNT_W  count of instructions that have committed.
REQ-019 halted  out  1  sticky halt flag.

Function
REQ-020 Latency: a captured input appears on every registered output exactly 1 cycle after the capturing edge.
REQ-021 wb_data selection at capture: jal=1 -> pc4; else mem_to_reg=1 -> mem_data; else alu; jal takes priority over mem_to_reg.
REQ-022 wb_reg selection at capture: jal=1 -> 31; else reg_dst=1 -> instruction[15:11]; else instruction[20:16].
REQ-023 Per-edge priority: rst, then halted (freeze), then clear, then go, then hold.
REQ-024 halted=1 and not rst: all registers hold; go and clear are ignored; retired does not increment.
REQ-025 clear=1 (not halted): all data outputs go to 0, valid_out=0, wb_en=0; this happens regardless of go.
REQ-026 go=1, clear=0: all fields are captured; valid_out=valid_in.
REQ-027 go=0, clear=0: all outputs hold, and an instruction that is held is not counted again.
REQ-028 retired increments by 1 on each edge that captures with valid_in=1 and ctrl_msg bit0 or bit3 set, and wraps modulo 2^CNT_W with no saturation.
REQ-029 halted is set on the edge that captures valid_in=1 with ctrl_msg bit3=1; that halt instruction is counted; halted stays set until rst.
REQ-030 A bubble (valid_in=0) is captured with its data, but wb_en=0, it is not counted, and it cannot set halted.
REQ-031 clear and go on the same edge as a valid halt: clear wins; no halt and no count.

Reset
REQ-032 rst=1 at an edge: all outputs go to 0 (instruction_out, ctrl_msg_out, wb_data, wb_reg, wb_en, valid_out, retired, halted).
REQ-033 rst overrides go, clear and halted in the same cycle.
REQ-034 rst asserted mid-stall or while halted clears all state; the first edge after rst deasserts behaves as a normal capture.

Verification
REQ-035 Load commit: valid_in=1, go=1, ctrl=0x013 (reg_write, mem_to_reg, reg_dst), instruction rd=5, mem_data=0xDEADBEEF -> next cycle wb_data=0xDEADBEEF, wb_reg=5, wb_en=1, retired=1.
REQ-036 jal: ctrl bits 0 and 2 set, pc4=0x00400008, alu=0x1234 -> wb_data=0x00400008, wb_reg=31.
REQ-037 Stall then flush: capture an add, go=0 for 3 cycles -> outputs unchanged and retired constant; clear=1 with go=1 -> valid_out=0, wb_en=0, wb_data=0.
REQ-038 Halt: capture a valid halt -> halted=1 and retired+1; further go=1 with new data -> outputs frozen; rst=1 -> all outputs 0.
REQ-039 Wrap: CNT_W=4, commit 17 reg_write instructions -> retired=1.
REQ-040 Bubble and collision: valid_in=0 with ctrl=0x001 -> wb_en=0, retired unchanged; halt with clear=1 on the same edge -> halted=0.
